// File: rtl/mc_if.sv
// Bus bundle between the multi-cycle controller and the datapath/memory side.
// The master side is the controller; the slave side is the datapath and memories.
interface mc_if #(
    parameter int W_CNT = 32
);
    logic [31:0]      instr;
    logic             zero;
    logic             imem_req;
    logic             imem_rdy;
    logic             dmem_req;
    logic             dmem_we;
    logic             dmem_rdy;
    logic             ir_we;
    logic             pc_we;
    logic [1:0]       npc_sel;
    logic             reg_we;
    logic [1:0]       reg_dst;
    logic [1:0]       wd_sel;
    logic             alu_src;
    logic [1:0]       alu_op;
    logic             ext_op;
    logic             illegal;
    logic [2:0]       state;
    logic [W_CNT-1:0] retired;

    modport master (
        input  instr, zero, imem_rdy, dmem_rdy,
        output imem_req, dmem_req, dmem_we, ir_we, pc_we, npc_sel, reg_we,
               reg_dst, wd_sel, alu_src, alu_op, ext_op, illegal, state, retired
    );

    modport slave (
        output instr, zero, imem_rdy, dmem_rdy,
        input  imem_req, dmem_req, dmem_we, ir_we, pc_we, npc_sel, reg_we,
               reg_dst, wd_sel, alu_src, alu_op, ext_op, illegal, state, retired
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle controller for the MIPS-subset CPU: sequences FETCH/DECODE/EXEC/MEM/WB,
// drives the datapath enables and selects, handshakes with both memories and counts
// retired instructions. All outputs are held at zero while reset is asserted.
module mc_ctrl #(
    parameter int W_CNT = 32
) (
    input logic  clk,
    input logic  reset,
    mc_if.master bus
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        I_ADDU, I_SUBU, I_JR, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_JAL, I_BAD
    } iclass_t;

    state_t           state_q, state_d;
    logic [W_CNT-1:0] retired_q, retired_d;
    logic             illegal_q, illegal_d;

    iclass_t          cls;
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             unused_instr_bits;

    // ALU controls implied by the instruction, shared by EXEC and the states that hold them
    logic             alu_src_a;
    logic [1:0]       alu_op_a;
    logic             ext_op_a;

    // Raw (pre-reset-gating) outputs
    logic             imem_req_c, dmem_req_c, dmem_we_c, ir_we_c, pc_we_c, reg_we_c;
    logic [1:0]       npc_sel_c, reg_dst_c, wd_sel_c, alu_op_c;
    logic             alu_src_c, ext_op_c;

    assign op                = bus.instr[31:26];
    assign funct             = bus.instr[5:0];
    assign unused_instr_bits = ^bus.instr[25:6];

    // Classify the current IR contents into the supported instruction set
    always_comb begin
        cls = I_BAD;
        case (op)
            6'b000000: begin
                case (funct)
                    6'b100001: cls = I_ADDU;
                    6'b100011: cls = I_SUBU;
                    6'b001000: cls = I_JR;
                    default:   cls = I_BAD;
                endcase
            end
            6'b001101: cls = I_ORI;
            6'b001111: cls = I_LUI;
            6'b100011: cls = I_LW;
            6'b101011: cls = I_SW;
            6'b000100: cls = I_BEQ;
            6'b000010: cls = I_J;
            6'b000011: cls = I_JAL;
            default:   cls = I_BAD;
        endcase
    end

    // ALU operand/operation selection per instruction class
    always_comb begin
        alu_src_a = 1'b0;
        alu_op_a  = 2'b00;
        ext_op_a  = 1'b0;
        case (cls)
            I_SUBU: alu_op_a = 2'b01;
            I_BEQ: begin
                alu_op_a = 2'b01;
                ext_op_a = 1'b1;
            end
            I_ORI: begin
                alu_src_a = 1'b1;
                alu_op_a  = 2'b10;
            end
            I_LUI: begin
                alu_src_a = 1'b1;
                alu_op_a  = 2'b11;
            end
            I_LW, I_SW: begin
                alu_src_a = 1'b1;
                ext_op_a  = 1'b1;
            end
            default: ;
        endcase
    end

    // Next-state and output decode for the instruction sequencer
    always_comb begin
        state_d    = state_q;
        illegal_d  = illegal_q;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        ir_we_c    = 1'b0;
        pc_we_c    = 1'b0;
        npc_sel_c  = 2'b00;
        reg_we_c   = 1'b0;
        reg_dst_c  = 2'b00;
        wd_sel_c   = 2'b00;
        alu_src_c  = 1'b0;
        alu_op_c   = 2'b00;
        ext_op_c   = 1'b0;
        case (state_q)
            FETCH: begin
                imem_req_c = 1'b1;
                if (bus.imem_rdy) begin
                    ir_we_c = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                case (cls)
                    I_J: begin
                        pc_we_c   = 1'b1;
                        npc_sel_c = 2'b10;
                        state_d   = FETCH;
                    end
                    I_JAL: begin
                        pc_we_c   = 1'b1;
                        npc_sel_c = 2'b10;
                        reg_we_c  = 1'b1;
                        reg_dst_c = 2'b10;
                        wd_sel_c  = 2'b10;
                        state_d   = FETCH;
                    end
                    I_JR: begin
                        pc_we_c   = 1'b1;
                        npc_sel_c = 2'b11;
                        state_d   = FETCH;
                    end
                    I_BAD: begin
                        illegal_d = 1'b1;
                        state_d   = HALT;
                    end
                    default: state_d = EXEC;
                endcase
            end
            EXEC: begin
                alu_src_c = alu_src_a;
                alu_op_c  = alu_op_a;
                ext_op_c  = ext_op_a;
                case (cls)
                    I_BEQ: begin
                        pc_we_c   = 1'b1;
                        npc_sel_c = bus.zero ? 2'b01 : 2'b00;
                        state_d   = FETCH;
                    end
                    I_LW, I_SW: state_d = MEM;
                    default:    state_d = WB;
                endcase
            end
            MEM: begin
                alu_src_c  = alu_src_a;
                alu_op_c   = alu_op_a;
                ext_op_c   = ext_op_a;
                dmem_req_c = 1'b1;
                dmem_we_c  = (cls == I_SW);
                if (bus.dmem_rdy) begin
                    if (cls == I_SW) begin
                        pc_we_c = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end
            end
            WB: begin
                alu_src_c = alu_src_a;
                alu_op_c  = alu_op_a;
                ext_op_c  = ext_op_a;
                reg_we_c  = 1'b1;
                pc_we_c   = 1'b1;
                reg_dst_c = (cls == I_ADDU || cls == I_SUBU) ? 2'b01 : 2'b00;
                wd_sel_c  = (cls == I_LW) ? 2'b01 : 2'b00;
                state_d   = FETCH;
            end
            HALT: ;
            default: state_d = FETCH;
        endcase
    end

    // Retired counter advances on every PC update, wrapping naturally
    always_comb begin
        retired_d = retired_q + W_CNT'(pc_we_c);
    end

    // State, sticky illegal flag and retired counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FETCH;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    // Outputs are forced low while reset is held so any outstanding request drops at once
    assign bus.imem_req = reset & imem_req_c;
    assign bus.dmem_req = reset & dmem_req_c;
    assign bus.dmem_we  = reset & dmem_we_c;
    assign bus.ir_we    = reset & ir_we_c;
    assign bus.pc_we    = reset & pc_we_c;
    assign bus.npc_sel  = reset ? npc_sel_c : 2'b00;
    assign bus.reg_we   = reset & reg_we_c;
    assign bus.reg_dst  = reset ? reg_dst_c : 2'b00;
    assign bus.wd_sel   = reset ? wd_sel_c : 2'b00;
    assign bus.alu_src  = reset & alu_src_c;
    assign bus.alu_op   = reset ? alu_op_c : 2'b00;
    assign bus.ext_op   = reset & ext_op_c;
    assign bus.illegal  = reset & illegal_q;
    assign bus.state    = reset ? state_q : 3'd0;
    assign bus.retired  = reset ? retired_q : '0;
endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed cases plus randomized instruction streams
// compared against a per-instruction cycle-sequence reference model.
`timescale 1ns/1ps
module tb_mc_ctrl;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mc_if #(.W_CNT(W)) bus ();
    mc_if #(.W_CNT(3)) bus3 ();

    mc_ctrl #(.W_CNT(W)) dut  (.clk(clk), .reset(reset), .bus(bus));
    mc_ctrl #(.W_CNT(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

    assign bus3.instr    = bus.instr;
    assign bus3.zero     = bus.zero;
    assign bus3.imem_rdy = bus.imem_rdy;
    assign bus3.dmem_rdy = bus.dmem_rdy;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] ret_m  = 0;

    // instruction class codes used by the model
    localparam int C_ADDU = 0, C_SUBU = 1, C_JR = 2, C_ORI = 3, C_LUI = 4,
                   C_LW = 5, C_SW = 6, C_BEQ = 7, C_J = 8, C_JAL = 9, C_BAD = 10;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] make_instr(input int c);
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] r;
        rs  = 5'($urandom);
        rt  = 5'($urandom);
        rd  = 5'($urandom);
        imm = 16'($urandom);
        tgt = 26'($urandom);
        case (c)
            C_ADDU:  r = {6'h00, rs, rt, rd, 5'h00, 6'h21};
            C_SUBU:  r = {6'h00, rs, rt, rd, 5'h00, 6'h23};
            C_JR:    r = {6'h00, rs, 15'h0000, 6'h08};
            C_ORI:   r = {6'h0d, rs, rt, imm};
            C_LUI:   r = {6'h0f, 5'h00, rt, imm};
            C_LW:    r = {6'h23, rs, rt, imm};
            C_SW:    r = {6'h2b, rs, rt, imm};
            C_BEQ:   r = {6'h04, rs, rt, imm};
            C_J:     r = {6'h02, tgt};
            C_JAL:   r = {6'h03, tgt};
            default: r = {6'h3f, tgt};
        endcase
        return r;
    endfunction

    // Drive one instruction through the controller and check every cycle against
    // the expected cycle sequence derived from the instruction's class and wait counts.
    task automatic run_instr(input logic [31:0] ins, input int c, input int iw,
                             input int dw, input logic z);
        int ph[$];
        int last;
        int memk;
        bit alu_cls, wr_cls;
        int e_op, e_src, e_ext, e_npc, e_dst, e_wd;
        for (int i = 0; i <= iw; i++) ph.push_back(0);
        ph.push_back(1);
        if (c == C_ADDU || c == C_SUBU || c == C_ORI || c == C_LUI) begin
            ph.push_back(2);
            ph.push_back(4);
        end else if (c == C_BEQ) begin
            ph.push_back(2);
        end else if (c == C_LW || c == C_SW) begin
            ph.push_back(2);
            for (int i = 0; i <= dw; i++) ph.push_back(3);
            if (c == C_LW) ph.push_back(4);
        end
        last = ph.size() - 1;
        memk = 0;

        alu_cls = (c == C_ADDU || c == C_SUBU || c == C_ORI || c == C_LUI ||
                   c == C_LW || c == C_SW || c == C_BEQ);
        wr_cls  = (c == C_JAL || c == C_ADDU || c == C_SUBU || c == C_ORI ||
                   c == C_LUI || c == C_LW);
        e_op  = (c == C_SUBU || c == C_BEQ) ? 1 : (c == C_ORI) ? 2 : (c == C_LUI) ? 3 : 0;
        e_src = (c == C_ADDU || c == C_SUBU || c == C_BEQ) ? 0 : 1;
        e_ext = (c == C_ORI) ? 0 : 1;
        e_npc = (c == C_J || c == C_JAL) ? 2 : (c == C_JR) ? 3 : (c == C_BEQ && z) ? 1 : 0;
        e_dst = (c == C_JAL) ? 2 : (c == C_ADDU || c == C_SUBU) ? 1 : 0;
        e_wd  = (c == C_JAL) ? 2 : (c == C_LW) ? 1 : 0;

        for (int k = 0; k <= last; k++) begin
            bus.instr    = ins;
            bus.zero     = z;
            bus.imem_rdy = (ph[k] == 0) ? (k == iw) : 1'($urandom_range(0, 1));
            bus.dmem_rdy = (ph[k] == 3) ? (memk == dw) : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (k == 0) begin
                chk("retired", bus.retired, ret_m);
                chk("retired_w3", 32'(bus3.retired), {29'd0, ret_m[2:0]});
            end
            chk("state",    32'(bus.state),    ph[k]);
            chk("imem_req", 32'(bus.imem_req), 32'(ph[k] == 0));
            chk("ir_we",    32'(bus.ir_we),    32'(k == iw));
            chk("dmem_req", 32'(bus.dmem_req), 32'(ph[k] == 3));
            chk("dmem_we",  32'(bus.dmem_we),  32'(ph[k] == 3 && c == C_SW));
            chk("pc_we",    32'(bus.pc_we),    32'(k == last && c != C_BAD));
            chk("reg_we",   32'(bus.reg_we),   32'(k == last && wr_cls));
            chk("illegal",  32'(bus.illegal),  0);
            if (k == last && c != C_BAD) chk("npc_sel", 32'(bus.npc_sel), e_npc);
            if (k == last && wr_cls) begin
                chk("reg_dst", 32'(bus.reg_dst), e_dst);
                chk("wd_sel",  32'(bus.wd_sel),  e_wd);
            end
            if (ph[k] >= 2 && alu_cls) begin
                chk("alu_op",  32'(bus.alu_op),  e_op);
                chk("alu_src", 32'(bus.alu_src), e_src);
                if (c == C_BEQ || c == C_LW || c == C_SW || c == C_ORI)
                    chk("ext_op", 32'(bus.ext_op), e_ext);
            end
            if (ph[k] == 3) memk++;
            @(posedge clk);
            #1;
        end
        if (c != C_BAD) ret_m = ret_m + 1;
    endtask

    int          c, iw, dw;
    logic        z;
    logic [31:0] ins;

    initial begin
        reset        = 1'b0;
        bus.instr    = 32'h0;
        bus.zero     = 1'b0;
        bus.imem_rdy = 1'b1;
        bus.dmem_rdy = 1'b1;

        // reset state: outputs forced low even with rdy inputs high
        repeat (2) @(negedge clk);
        chk("rst_state",    32'(bus.state),    0);
        chk("rst_imem_req", 32'(bus.imem_req), 0);
        chk("rst_pc_we",    32'(bus.pc_we),    0);
        chk("rst_retired",  bus.retired,       0);
        chk("rst_illegal",  32'(bus.illegal),  0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // directed cases
        run_instr(32'h00851021, C_ADDU, 2, 0, 1'b0);
        run_instr(32'h1000FFFF, C_BEQ, 0, 0, 1'b1);
        run_instr(32'h1000FFFF, C_BEQ, 0, 0, 1'b0);
        run_instr(32'h8C820004, C_LW, 0, 3, 1'b0);
        run_instr(32'h0C000010, C_JAL, 0, 0, 1'b0);
        run_instr(32'h03E00008, C_JR, 0, 0, 1'b0);

        // randomized stream, long enough to wrap the narrow counter several times
        for (int n = 0; n < 300; n++) begin
            c   = $urandom_range(0, 9);
            iw  = $urandom_range(0, 2);
            dw  = $urandom_range(0, 3);
            z   = 1'($urandom_range(0, 1));
            ins = make_instr(c);
            run_instr(ins, c, iw, dw, z);
        end

        // undecoded R-type funct is illegal too; then the plan's undecoded opcode after reset
        run_instr({6'h00, 20'h12345, 6'h3f}, C_BAD, 1, 0, 1'b0);
        bus.imem_rdy = 1'b1;
        bus.dmem_rdy = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("halt_state",   32'(bus.state),    5);
            chk("halt_illegal", 32'(bus.illegal),  1);
            chk("halt_imem",    32'(bus.imem_req), 0);
            chk("halt_pc_we",   32'(bus.pc_we),    0);
            chk("halt_retired", bus.retired,       ret_m);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_halt_illegal", 32'(bus.illegal), 0);
        chk("rst_halt_state",   32'(bus.state),   0);
        bus.imem_rdy = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        ret_m = 0;
        run_instr(32'hFC000000, C_BAD, 0, 0, 1'b0);
        repeat (2) begin
            @(negedge clk);
            chk("halt2_state",   32'(bus.state),    5);
            chk("halt2_illegal", 32'(bus.illegal),  1);
            chk("halt2_imem",    32'(bus.imem_req), 0);
            chk("halt2_retired", bus.retired,       0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst2_illegal", 32'(bus.illegal), 0);
        chk("rst2_state",   32'(bus.state),   0);
        bus.imem_rdy = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        ret_m = 0;

        // reset pulsed in the middle of a stalled sw access
        run_instr(32'h00851021, C_ADDU, 0, 0, 1'b0);
        bus.instr    = 32'hAC820008;
        bus.imem_rdy = 1'b1;
        bus.dmem_rdy = 1'b0;
        @(posedge clk);
        #1;
        bus.imem_rdy = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("sw_mem_state", 32'(bus.state),    3);
        chk("sw_mem_req",   32'(bus.dmem_req), 1);
        chk("sw_mem_we",    32'(bus.dmem_we),  1);
        chk("sw_retired",   bus.retired,       1);
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_dmem_req", 32'(bus.dmem_req), 0);
        chk("midrst_dmem_we",  32'(bus.dmem_we),  0);
        chk("midrst_state",    32'(bus.state),    0);
        chk("midrst_retired",  bus.retired,       0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("post_imem_req", 32'(bus.imem_req), 1);
        chk("post_state",    32'(bus.state),    0);
        chk("post_retired",  bus.retired,       0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle controller that sequences the single-ported fetch/next-PC/ALU/memory datapath of the MIPS-subset CPU. It walks each instruction through FETCH, DECODE, EXEC, MEM and WB states and decides when the PC register loads. It selects which next-PC source (PC+4, branch, jump-immediate, jr-register) the NPC logic forwards. It also performs req/rdy handshakes with instruction and data memory and counts retired instructions.

Parameters:
W_CNT, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
instr  input  32  current IR contents
zero  input  1  ALU zero flag
imem_req  output  1  instruction fetch request
imem_rdy  input  1  instruction word valid this cycle
dmem_req  output  1  data memory request
dmem_we  output  1  data memory write (sw)
dmem_rdy  input  1  data access complete; load data valid and captured by datapath MDR this cycle
ir_we  output  1  IR load enable
pc_we  output  1  PC load enable
npc_sel  output  2  00 PC+4, 01 branch, 10 jump-imm, 11 jr register
reg_we  output  1  GPR write enable
reg_dst  output  2  00 rt, 01 rd, 10 $31
wd_sel  output  2  00 ALU, 01 MDR, 10 PC+4
alu_src  output  1  0 rt, 1 extended imm
alu_op  output  2  00 add, 01 sub, 10 or, 11 lui
ext_op  output  1  1 sign-extend, 0 zero-extend
illegal  output  1  sticky: undecoded instruction seen
state  output  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5
retired  output  W_CNT  instructions retired, wraps modulo 2^W_CNT

Behaviour:
- Decoded set:
  - R-type (op 000000): funct 100001 addu, 100011 subu, 001000 jr.
  - ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
  - Anything else is illegal.
- Reset (reset=0, async):
  - state=FETCH, retired=0, illegal=0.
  - All outputs are forced to 0 while reset is low, including imem_req and dmem_req.
  - Reset asserted mid-access drops any outstanding request in the same cycle.
- Outputs are combinational from state, instr, zero and the rdy inputs. Every enable not listed for a state is 0.
- FETCH:
  - imem_req=1; hold state until imem_rdy.
  - On imem_rdy: ir_we=1, next state DECODE.
- DECODE (1 cycle):
  - j: pc_we=1, npc_sel=10, next FETCH.
  - jal: pc_we=1, npc_sel=10, reg_we=1, reg_dst=10, wd_sel=10, next FETCH.
  - jr: pc_we=1, npc_sel=11, next FETCH.
  - illegal: illegal set to 1, pc_we=0, next HALT.
  - All other instructions: next EXEC.
- EXEC:
  - beq: alu_src=0, alu_op=01, ext_op=1, pc_we=1, npc_sel = zero ? 01 : 00, next FETCH.
  - addu/subu: alu_src=0, alu_op=00/01, next WB.
  - ori: alu_src=1, ext_op=0, alu_op=10, next WB.
  - lui: alu_src=1, alu_op=11, next WB.
  - lw/sw: alu_src=1, ext_op=1, alu_op=00, next MEM.
- MEM:
  - dmem_req=1, dmem_we=(sw); ALU controls are held from EXEC.
  - Hold state until dmem_rdy.
  - On dmem_rdy, sw: pc_we=1, npc_sel=00, next FETCH.
  - On dmem_rdy, lw: next WB.
- WB (1 cycle):
  - reg_we=1, pc_we=1, npc_sel=00.
  - reg_dst = 01 for addu/subu, 00 for ori/lui/lw.
  - wd_sel = 01 for lw, 00 otherwise.
  - ALU controls are held; next FETCH.
- HALT:
  - Absorbing state; all enables 0; leaves only via reset.
- pc_we rules:
  - pc_we is high for exactly one cycle per retired instruction.
  - retired increments on every cycle with pc_we=1. At all-ones it wraps to 0.
- imem_rdy outside FETCH and dmem_rdy outside MEM are ignored.
- instr must be stable from DECODE until the next FETCH; the controller never writes IR outside FETCH.
- Cycle counts with zero memory wait (rdy in the first request cycle):
  - j/jal/jr: 2 cycles.
  - beq: 3.
  - R-type/ori/lui: 4.
  - sw: 4.
  - lw: 5.
  - Each wait cycle on imem_rdy or dmem_rdy adds one.

Test Plan:
- Reset release, imem_rdy held 0 for 2 cycles then instr=addu (0x00851021) with rdy -> imem_req high 3 cycles, then DECODE, EXEC, WB. In WB: reg_we=1, reg_dst=01, pc_we=1, npc_sel=00. retired=1.
- beq (0x1000FFFF) with zero=1, then again with zero=0 -> EXEC pc_we=1 with npc_sel=01, then 00. 3 cycles each; retired +2.
- lw (0x8C820004) with dmem_rdy after 3 wait cycles -> dmem_req high 4 cycles, dmem_we=0. WB has wd_sel=01, reg_dst=00. Total 8 cycles.
- jal (0x0C000010) then jr (0x03E00008) -> jal DECODE: pc_we=1, npc_sel=10, reg_we=1, reg_dst=10, wd_sel=10. jr: npc_sel=11, no reg_we.
- instr=0xFC000000 -> illegal=1, state=5, no further imem_req, retired unchanged. Deassert reset -> illegal=0, state=0.
- reset pulsed low mid-MEM of sw with dmem_rdy=0 -> dmem_req drops same cycle. state=0, retired=0. After release, first-cycle imem_req=1.
